// File: rtl/bin_bcd_sev_scan.sv
`default_nettype none
// ============================================================================
// Module   : bin_bcd_sev_scan
// Brief    : Serial double-dabble binary-to-BCD converter feeding a
//            time-multiplexed 7-segment scan driver with leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module bin_bcd_sev_scan #(
  parameter int BIN_W    = 9,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en
);

  function automatic longint unsigned f_pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam longint unsigned c_MAXBIN = (64'd1 << BIN_W) - 64'd1;
  localparam longint unsigned c_POW10  = f_pow10(DIGITS);
  localparam int c_CW = $clog2(BIN_W + 1);
  localparam int c_PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_SHIFT = 2'd1;
  localparam logic [1:0] c_S_DONE  = 2'd2;

  if (c_POW10 <= c_MAXBIN) begin : g_range_chk
    $fatal(1, "bin_bcd_sev_scan: DIGITS too small for BIN_W");
  end

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [BIN_W-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_scratch;
  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_scratch_nxt;
  logic [c_CW-1:0]     r_cnt;
  logic [4*DIGITS-1:0] r_bcd;
  logic [c_PW-1:0]     r_pre;
  logic [c_IW-1:0]     r_idx;
  logic [3:0]          w_dig [DIGITS];
  logic [DIGITS-1:0]   w_zero_from;
  logic [3:0]          w_cur;
  logic [6:0]          w_seg_raw;
  logic                w_blank;
  logic                w_last;

  assign w_last = (r_cnt == c_CW'(1));

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                              r_scratch[4*gi +: 4] + 4'd3 : r_scratch[4*gi +: 4];
    assign w_dig[gi] = r_bcd[4*gi +: 4];
  end

  assign w_scratch_nxt = {w_adj[4*DIGITS-2:0], r_shift[BIN_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:  if (load) w_state_nxt = c_S_SHIFT;
      c_S_SHIFT: if (w_last) w_state_nxt = c_S_DONE;
      c_S_DONE:  w_state_nxt = c_S_IDLE;
      default:   w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == c_S_SHIFT);
    done = (r_state == c_S_DONE);
  end

  // Result is committed on the final shift edge so it is visible alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (load) begin
            r_shift   <= bin_in;
            r_scratch <= '0;
            r_cnt     <= c_CW'(BIN_W);
          end
        end
        c_S_SHIFT: begin
          r_scratch <= w_scratch_nxt;
          r_shift   <= r_shift << 1;
          r_cnt     <= r_cnt - c_CW'(1);
          if (w_last) r_bcd <= w_scratch_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bcd_out = r_bcd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == c_PW'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= (r_idx == c_IW'(DIGITS - 1)) ? '0 : r_idx + c_IW'(1);
    end else begin
      r_pre <= r_pre + c_PW'(1);
    end
  end

  // w_zero_from[i]: every digit at position i and above is zero.
  always_comb begin
    w_zero_from = '0;
    w_zero_from[DIGITS-1] = (w_dig[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--)
      w_zero_from[i] = (w_dig[i] == 4'd0) && w_zero_from[i+1];
  end

  always_comb begin
    w_cur   = w_dig[r_idx];
    w_blank = blank_lz && (r_idx != '0) && w_zero_from[r_idx];
    case (w_cur)
      4'd0:    w_seg_raw = 7'b1111110;
      4'd1:    w_seg_raw = 7'b0110000;
      4'd2:    w_seg_raw = 7'b1101101;
      4'd3:    w_seg_raw = 7'b1111001;
      4'd4:    w_seg_raw = 7'b0110011;
      4'd5:    w_seg_raw = 7'b1011011;
      4'd6:    w_seg_raw = 7'b1011111;
      4'd7:    w_seg_raw = 7'b1110000;
      4'd8:    w_seg_raw = 7'b1111111;
      4'd9:    w_seg_raw = 7'b1111011;
      default: w_seg_raw = 7'b0000000;
    endcase
    seg = w_blank ? 7'b0000000 : w_seg_raw;
  end

  assign dig_en = DIGITS'(1) << r_idx;

endmodule
`default_nettype wire

// File: tb/tb_bin_bcd_sev_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_bcd_sev_scan
// Brief    : Directed self-checking bench for bin_bcd_sev_scan.
// Revision : 1.0  initial release
// ============================================================================
module tb_bin_bcd_sev_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [8:0]  bin_in = '0;
  logic        busy, done;
  logic [11:0] bcd_out;
  logic [6:0]  seg;
  logic [2:0]  dig_en;

  logic        load2 = 1'b0;
  logic [13:0] bin2 = '0;
  logic        busy2, done2;
  logic [19:0] bcd2;
  logic [6:0]  seg2;
  logic [4:0]  en2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin_bcd_sev_scan dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bin_in(bin_in), .blank_lz(blank_lz),
    .busy(busy), .done(done), .bcd_out(bcd_out), .seg(seg), .dig_en(dig_en)
  );

  bin_bcd_sev_scan #(.BIN_W(14), .DIGITS(5), .SCAN_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .bin_in(bin2), .blank_lz(1'b0),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .seg(seg2), .dig_en(en2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load at the next edge, then check busy window, done pulse and result.
  task automatic conv1(input logic [8:0] v, input logic [11:0] exp, input logic [11:0] prev);
    bin_in = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      chk("busy_win", busy, 1);
      chk("done_early", done, 0);
      if (i == 5) chk("bcd_hold", bcd_out, prev);
      @(negedge clk);
    end
    chk("done_pulse", done, 1);
    chk("busy_off", busy, 0);
    chk("bcd_result", bcd_out, exp);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic scan_check(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
    logic [2:0] prev;
    logic [2:0] exp_en;
    logic [6:0] exp_seg;
    bit found;
    found = 1'b0;
    prev  = dig_en;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (dig_en == 3'b001 && prev != 3'b001) found = 1'b1;
      else prev = dig_en;
    end
    chk("scan_sync", found, 1);
    for (int j = 0; j < 12; j++) begin
      exp_en  = 3'b001 << (j / 4);
      exp_seg = (j < 4) ? s0 : (j < 8) ? s1 : s2;
      chk("scan_en", dig_en, exp_en);
      chk("scan_seg", seg, exp_seg);
      @(negedge clk);
    end
  endtask

  initial begin
    bit any_done;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 12'h000);
    chk("rst_en", dig_en, 3'b001);
    chk("rst_seg", seg, 7'b1111110);
    rst_n = 1'b1;
    @(negedge clk);

    conv1(9'd511, 12'h511, 12'h000);
    scan_check(7'b0110000, 7'b0110000, 7'b1011011);

    // load held high with changing bin_in: only the first value converts
    bin_in = 9'd5;
    load   = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 9; i++) begin
      chk("held_busy", busy, 1);
      bin_in = 9'(100 + i);
      @(negedge clk);
    end
    chk("held_done", done, 1);
    chk("held_bcd", bcd_out, 12'h005);
    bin_in = 9'd42;
    @(negedge clk);
    chk("held_idle_busy", busy, 0);
    chk("held_idle_done", done, 0);
    @(negedge clk);
    load = 1'b0;
    chk("held_reaccept", busy, 1);
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      chk("held2_busy", busy, 1);
      chk("held2_hold", bcd_out, 12'h005);
    end
    @(negedge clk);
    chk("held2_done", done, 1);
    chk("held2_bcd", bcd_out, 12'h042);
    @(negedge clk);

    conv1(9'd256, 12'h256, 12'h042);
    conv1(9'd7, 12'h007, 12'h256);
    blank_lz = 1'b1;
    scan_check(7'b1110000, 7'b0000000, 7'b0000000);
    blank_lz = 1'b0;
    scan_check(7'b1110000, 7'b1111110, 7'b1111110);

    // asynchronous reset in the middle of a conversion
    bin_in = 9'd300;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd_out, 12'h000);
    chk("abort_en", dig_en, 3'b001);
    chk("abort_seg", seg, 7'b1111110);
    chk("abort_bcd2", bcd2, 20'h00000);
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    chk("abort_no_done", any_done, 0);
    conv1(9'd300, 12'h300, 12'h000);

    conv1(9'd50, 12'h050, 12'h300);
    blank_lz = 1'b1;
    scan_check(7'b1111110, 7'b1011011, 7'b0000000);
    blank_lz = 1'b0;
    conv1(9'd0, 12'h000, 12'h050);

    // wide instance: 14-bit input, 5 digits
    bin2  = 14'd9999;
    load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      chk("w_busy", busy2, 1);
      chk("w_done_early", done2, 0);
      @(negedge clk);
    end
    chk("w_done", done2, 1);
    chk("w_bcd", bcd2, 20'h09999);
    @(negedge clk);
    bin2  = 14'd16383;
    load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    repeat (14) @(negedge clk);
    chk("w_done2", done2, 1);
    chk("w_bcd2", bcd2, 20'h16383);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin_bcd_sev_scan.md
Name: bin_bcd_sev_scan

Overview:
- Sequential, parametrised binary-to-BCD converter with a time-multiplexed multi-digit 7-segment driver.
- Replaces the purely combinational add-3 array and per-digit decoders in the display path.
- Conversion uses serial shift-add-3 (double dabble), one input bit per clock, under a load/busy/done handshake.
- A scan engine strobes one digit at a time through a shared segment bus, with optional leading-zero blanking.

Parameters:
- BIN_W, 9, binary input width in bits (>=1).
- DIGITS, 3, number of BCD digits and display positions. Elaboration must fail fatally unless 10^DIGITS > 2^BIN_W-1.
- SCAN_DIV, 4, clock cycles each digit stays enabled (>=1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- load  input  1  start request; sampled only in IDLE.
- bin_in  input  BIN_W  binary value; captured on the accepted load edge.
- blank_lz  input  1  1 = blank leading zero digits.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out updates.
- bcd_out  output  4*DIGITS  packed BCD, digit 0 (ones) in bits [3:0].
- seg  output  7  {a,b,c,d,e,f,g}, active-high.
- dig_en  output  DIGITS  one-hot digit enable, active-high, bit 0 = ones.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - FSM=IDLE, busy=0, done=0, bcd_out=0.
  - Scan index=0, prescaler=0, so dig_en=1 and seg=1111110.
  - Reset asserted mid-conversion aborts it: no done pulse, bcd_out returns to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On a clock edge with load=1, capture bin_in into the shift register.
  - Clear the BCD scratch register, set bit counter=BIN_W, go to SHIFT.
- SHIFT, each cycle:
  - Every scratch nibble >=5 gets +3 (all nibbles in parallel, 4-bit modulo).
  - Then {scratch, shift} shifts left 1, moving the binary MSB into the scratch LSB.
  - Decrement the counter; when the last bit has shifted, go to DONE.
  - SHIFT lasts exactly BIN_W cycles.
- DONE, one cycle:
  - bcd_out <= scratch, done=1, then go to IDLE.
  - load is not accepted in DONE.
- Latency and handshake:
  - Load accepted at edge k: busy=1 for cycles k+1..k+BIN_W.
  - done=1 and the new bcd_out are visible in cycle k+BIN_W+1.
  - A new load is accepted at the earliest at edge k+BIN_W+2.
  - load while busy or in DONE is ignored, not queued.
  - bcd_out holds its previous value throughout a conversion, so the display does not flicker.
- Scan engine (free-running, independent of the FSM):
  - Prescaler counts 0..SCAN_DIV-1. On wrap, the scan index advances 0..DIGITS-1, then wraps to 0.
  - dig_en = one-hot(index). seg = decode(bcd_out digit[index]). Both are combinational from registers, so they change on the same edge as the index.
- Decode table:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Codes 10-15 give 0000000.
- Blanking:
  - If blank_lz=1, index>0, and every digit at positions >=index is 0, then seg=0000000 while dig_en remains asserted.
  - Digit 0 is never blanked.
  - blank_lz acts combinationally.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> outputs take reset values immediately (dig_en=001, seg=1111110, busy=0, done=0).
- Defaults, load bin_in=511 at edge k -> busy high 9 cycles, done pulse in cycle k+10, bcd_out=0x511.
- Same run, observing the scan -> scan shows 1 (0110000) on dig_en=001, 1 on 010, 5 (1011011) on 100, each for 4 cycles.
- load=1 held continuously with bin_in changing -> only the first value converts; next acceptance at edge k+11; no queued conversions.
- bin_in=7, blank_lz=1 -> dig_en=100 and 010 give seg=0000000, dig_en=001 gives 1110000. With blank_lz=0, the upper digits show 1111110.
- Drop rst_n in SHIFT after bin_in=300 -> no done; bcd_out=0; a subsequent load of 300 yields 0x300 in 10 cycles.
- BIN_W=14, DIGITS=5: load 9999 -> done in cycle k+15, bcd_out=0x09999. Elaborating BIN_W=14, DIGITS=4 must fail.
